// File: rtl/branch_resolver_if.sv
// Handshake bundle between fetch/execute and branch_resolver.
// Build option BRANCH_RESOLVER_STATS_EN enables the statistics counters.
interface branch_resolver_if #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
);
  logic                     pred_valid;
  logic                     pred_taken;
  logic                     pred_ready;
  logic                     res_valid;
  logic                     res_taken;
  logic                     upd_valid;
  logic                     upd_taken;
  logic                     mispredict;
  logic [$clog2(DEPTH):0]   count;
  logic                     err;
  logic [CNT_W-1:0]         branch_cnt;
  logic [CNT_W-1:0]         miss_cnt;

  modport master (
    output pred_valid, pred_taken,
    output res_valid, res_taken,
    input  pred_ready, upd_valid, upd_taken,
    input  mispredict, count, err,
    input  branch_cnt, miss_cnt
  );

  modport slave (
    input  pred_valid, pred_taken,
    input  res_valid, res_taken,
    output pred_ready, upd_valid, upd_taken,
    output mispredict, count, err,
    output branch_cnt, miss_cnt
  );
endinterface

// File: rtl/branch_resolver.sv
// In-order queue of fetch predictions resolved against execute outcomes;
// drives predictor training (upd_*) and a one-cycle mispredict flush.
// Ports: clk, rst (sync, active-high), bus (branch_resolver_if.slave):
//   pred_valid/pred_taken/pred_ready push side, res_valid/res_taken
//   resolve side, upd_valid/upd_taken/mispredict/count/err status,
//   branch_cnt/miss_cnt statistics (built only with the macro
//   BRANCH_RESOLVER_STATS_EN, otherwise tied to 0).
module branch_resolver #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  branch_resolver_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             upd_v_q, upd_v_d;
  logic             upd_t_q, upd_t_d;
  logic             mis_q, mis_d;
  logic             err_q, err_d;

  logic push, pop, miss, empty;

  assign empty = (cnt_q == '0);
  assign push  = bus.pred_valid && (cnt_q != FULL);
  assign pop   = bus.res_valid && !empty;
  assign miss  = pop && (bus.res_taken != mem_q[rd_q]);

  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    upd_v_d = pop;
    upd_t_d = pop ? bus.res_taken : upd_t_q;
    mis_d   = miss;
    err_d   = err_q | (bus.res_valid && empty);
    if (pop)
      rd_d = rd_q + 1'b1;
    // A push in the same cycle as a miss is wrong-path: drop it.
    if (push && !miss) begin
      mem_d[wr_q] = bus.pred_taken;
      wr_d        = wr_q + 1'b1;
    end
    if (miss) begin
      wr_d  = rd_q + 1'b1;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      upd_v_q <= 1'b0;
      upd_t_q <= 1'b0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      upd_v_q <= upd_v_d;
      upd_t_q <= upd_t_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
    end
  end

  assign bus.pred_ready = (cnt_q != FULL);
  assign bus.count      = cnt_q;
  assign bus.upd_valid  = upd_v_q;
  assign bus.upd_taken  = upd_t_q;
  assign bus.mispredict = mis_q;
  assign bus.err        = err_q;

`ifdef BRANCH_RESOLVER_STATS_EN
  logic [CNT_W-1:0] br_q, ms_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      br_q <= '0;
      ms_q <= '0;
    end else begin
      if (pop && (br_q != '1))
        br_q <= br_q + 1'b1;
      if (miss && (ms_q != '1))
        ms_q <= ms_q + 1'b1;
    end
  end

  assign bus.branch_cnt = br_q;
  assign bus.miss_cnt   = ms_q;
`else
  assign bus.branch_cnt = {CNT_W{1'b0}};
  assign bus.miss_cnt   = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_branch_resolver.sv
// Randomized + directed bench for branch_resolver against a queue model.
// Two DUTs share stimulus: CNT_W=16 and CNT_W=2 (saturation).
module tb_branch_resolver;
  localparam int DEPTH = 4;
`ifdef BRANCH_RESOLVER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_resolver_if #(.DEPTH(DEPTH), .CNT_W(16)) b1 ();
  branch_resolver_if #(.DEPTH(DEPTH), .CNT_W(2))  b2 ();

  assign b2.pred_valid = b1.pred_valid;
  assign b2.pred_taken = b1.pred_taken;
  assign b2.res_valid  = b1.res_valid;
  assign b2.res_taken  = b1.res_taken;

  branch_resolver #(.DEPTH(DEPTH), .CNT_W(16)) u1 (
    .clk (clk),
    .rst (rst),
    .bus (b1.slave)
  );

  branch_resolver #(.DEPTH(DEPTH), .CNT_W(2)) u2 (
    .clk (clk),
    .rst (rst),
    .bus (b2.slave)
  );

  int checks = 0;
  int failures = 0;
  bit run = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: queue of outstanding predictions.
  bit pq[$];
  bit e_uv, e_ut, e_mp, e_err, m_push, m_h;
  int br, ms;

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    if (!STATS) return 0;
    return (v > mx) ? mx : v;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      pq.delete();
      e_uv = 0; e_ut = 0; e_mp = 0; e_err = 0;
      br = 0; ms = 0;
    end else begin
      m_push = b1.pred_valid && (pq.size() < DEPTH);
      e_uv = 0;
      e_mp = 0;
      if (b1.res_valid && pq.size() == 0) e_err = 1;
      if (b1.res_valid && pq.size() > 0) begin
        m_h  = pq.pop_front();
        e_uv = 1;
        e_ut = b1.res_taken;
        br++;
        if (m_h != b1.res_taken) begin
          e_mp = 1;
          ms++;
          pq.delete();
          m_push = 0;
        end
      end
      if (m_push) pq.push_back(b1.pred_taken);
    end
  end

  // Compare process, mid-cycle.
  always @(negedge clk) begin
    if (run) begin
      chk("ready", b1.pred_ready, pq.size() < DEPTH);
      chk("count", b1.count, pq.size());
      chk("upd_valid", b1.upd_valid, e_uv);
      if (e_uv) chk("upd_taken", b1.upd_taken, e_ut);
      chk("mispredict", b1.mispredict, e_mp);
      chk("err", b1.err, e_err);
      chk("branch_cnt", b1.branch_cnt, sat(br, 16));
      chk("miss_cnt", b1.miss_cnt, sat(ms, 16));
      chk("branch_cnt2", b2.branch_cnt, sat(br, 2));
      chk("miss_cnt2", b2.miss_cnt, sat(ms, 2));
      chk("count2", b2.count, pq.size());
    end
  end

  task automatic step(input bit r, input bit pv, input bit pt,
                      input bit rv, input bit rt);
    rst           = r;
    b1.pred_valid = pv;
    b1.pred_taken = pt;
    b1.res_valid  = rv;
    b1.res_taken  = rt;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
  endtask

  initial begin
    b1.pred_valid = 0;
    b1.pred_taken = 0;
    b1.res_valid  = 0;
    b1.res_taken  = 0;
    do_reset();
    run = 1'b1;
    chk("rst_count", b1.count, 0);
    chk("rst_ready", b1.pred_ready, 1);
    chk("rst_upd", b1.upd_valid, 0);
    chk("rst_err", b1.err, 0);

    // In-order hits
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("push3_count", b1.count, 3);
    step(0, 0, 0, 1, 1);
    chk("hit1_taken", b1.upd_taken, 1);
    step(0, 0, 0, 1, 1);
    chk("hit2_taken", b1.upd_taken, 1);
    step(0, 0, 0, 1, 0);
    chk("hit3_valid", b1.upd_valid, 1);
    chk("hit3_taken", b1.upd_taken, 0);
    chk("hit3_mis", b1.mispredict, 0);
    chk("hits_count", b1.count, 0);
    chk("hits_br", b1.branch_cnt, STATS ? 3 : 0);

    // Mispredict flush
    step(0, 1, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    chk("fl_count3", b1.count, 3);
    step(0, 0, 0, 1, 0);
    chk("fl_mis", b1.mispredict, 1);
    chk("fl_taken", b1.upd_taken, 0);
    chk("fl_count0", b1.count, 0);
    chk("fl_miss_cnt", b1.miss_cnt, STATS ? 1 : 0);
    step(0, 0, 0, 1, 0);
    chk("fl_err", b1.err, 1);
    chk("fl_noupd", b1.upd_valid, 0);

    // Full
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 1, 0, 0);
      if (i == 3) chk("full_ready", b1.pred_ready, 0);
    end
    chk("full_count", b1.count, 4);
    step(0, 1, 1, 1, 1);
    chk("full_pp_count", b1.count, 3);
    chk("full_pp_upd", b1.upd_valid, 1);

    // Wrap
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(0, 1, i[0], 0, 0);
      step(0, 0, 0, 1, i[0]);
    end
    chk("wrap_br", b1.branch_cnt, STATS ? 10 : 0);
    chk("wrap_miss", b1.miss_cnt, 0);

    // Push + miss in one cycle
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 1, 0);
    chk("pm_count", b1.count, 0);
    step(0, 0, 0, 1, 1);
    chk("pm_gone_err", b1.err, 1);

    // Reset mid-operation with resolve
    do_reset();
    step(0, 1, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    step(1, 0, 0, 1, 0);
    chk("mr_count", b1.count, 0);
    chk("mr_ready", b1.pred_ready, 1);
    chk("mr_upd", b1.upd_valid, 0);
    chk("mr_mis", b1.mispredict, 0);
    chk("mr_br", b1.branch_cnt, 0);

    // Saturation on the CNT_W=2 instance
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 1, 0, 0);
      step(0, 0, 0, 1, 0);
    end
    chk("sat_miss2", b2.miss_cnt, STATS ? 3 : 0);
    chk("sat_miss16", b1.miss_cnt, STATS ? 5 : 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 97) == 0,
           ($urandom % 100) < 55, $urandom % 2,
           ($urandom % 100) < 45, ($urandom % 4) != 0);
    end

    @(negedge clk);
    run = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/branch_resolver.md
# branch_resolver

Resolution end of the 2-bit branch predictor interface. Holds the predictions issued at fetch in an in-order queue, compares each against the actual outcome reported by execute, and drives the predictor's training input (`upd_valid`/`upd_taken`) plus a one-cycle mispredict/flush pulse. On a mispredict it discards every younger in-flight prediction and can keep accuracy statistics.

## Interface
- `DEPTH`, 4: in-flight branch capacity; power of two, ≥2.
- `CNT_W`, 16: width of each statistics counter.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `pred_valid`  in  1  fetch issues a predicted branch this cycle.
- `pred_taken`  in  1  prediction for that branch (predictor `predict` output).
- `pred_ready`  out  1  queue can accept a push; `count != DEPTH`.
- `res_valid`  in  1  execute resolves the oldest in-flight branch.
- `res_taken`  in  1  actual outcome of that branch.
- `upd_valid`  out  1  registered one-cycle training strobe to the predictor.
- `upd_taken`  out  1  actual outcome to the predictor's `taken` input; valid with `upd_valid`.
- `mispredict`  out  1  registered one-cycle flush pulse.
- `count`  out  $clog2(DEPTH)+1  current queue occupancy.
- `err`  out  1  sticky protocol error: resolve while the queue is empty.
- `branch_cnt`  out  CNT_W  resolved branches; saturating.
- `miss_cnt`  out  CNT_W  mispredicted branches; saturating.

## Operation
- **Push:**
  - A push is accepted when `pred_valid && pred_ready`.
  - It writes `pred_taken` at the write pointer, advances the pointer mod DEPTH and increments `count`.
- **Pop:**
  - A pop is accepted when `res_valid && count != 0`.
  - It reads the head entry, advances the read pointer mod DEPTH and decrements `count`.
- **Compare:**
  - A miss is recorded when `res_taken != head_pred`.
  - A hit sets `upd_valid=1`, `upd_taken=res_taken` and `mispredict=0`, all registered.
  - A miss sets `upd_valid=1`, `upd_taken=res_taken` and `mispredict=1`.
  - On a miss, the same edge sets both pointers equal and clears `count` to 0, discarding the younger wrong-path entries.
- **Simultaneous push and pop:**
  - On a hit, both are performed and `count` is unchanged.
  - On a miss, the push is dropped because it is wrong-path, and `count` becomes 0.
- **Full:**
  - `pred_ready` depends only on registered `count`. There is no combinational path from `res_valid`.
  - When full, a push is refused even in a cycle that also pops.
- **Empty resolve:** `res_valid` while `count == 0` produces no update and no mispredict. It sets `err=1`, which holds until `rst`.
- **Pointer wrap:** pointers are $clog2(DEPTH) bits and wrap naturally.
- **Reset:**
  - Synchronous reset clears the pointers, `count`, `upd_valid`, `upd_taken`, `mispredict`, `err` and both counters.
  - A reset asserted mid-operation discards all entries. Any resolve in the same cycle is ignored.

## Timing
- Reset values: `pred_ready=1`, `count=0`; every other output 0.
- Resolve latency: `res_valid` at edge N produces `upd_valid`, `upd_taken` and `mispredict` during cycle N+1. Each is high for exactly one cycle per resolve.
- Back-to-back resolves produce back-to-back `upd_valid` pulses.
- `count` and `pred_ready` reflect the state after edge N in cycle N+1.
- After a mispredict at edge N, the first push is accepted at edge N+1.
- Counters update at the same edge as the pop and are visible in cycle N+1:
  - `branch_cnt` increments on every pop.
  - `miss_cnt` increments on every miss.
  - Both saturate at 2^CNT_W−1.

## Configuration
- `BRANCH_RESOLVER_STATS_EN`:
  - Defined: the `branch_cnt` and `miss_cnt` registers are built as described above.
  - Undefined: no counter registers are built, and both ports are tied to constant 0.
- All other behaviour is identical in both builds.

## Test plan
- **Reset, then push/resolve:** reset, then push T,T,N. Resolve T,T,N → three `upd_valid` pulses with `upd_taken`=1,1,0, `mispredict` never high, `count` ends 0, `branch_cnt`=3, `miss_cnt`=0.
- **Mispredict flush:** push T,N,T (`count`=3), then resolve N → `mispredict`=1 and `upd_taken`=0 next cycle, `count`=0, `miss_cnt`=1. A following resolve sets `err`=1.
- **Full, DEPTH=4:**
  - Push 5 consecutive cycles → `pred_ready`=0 after the 4th and the 5th is refused (`count`=4).
  - A push plus hit-resolve in the same full cycle → push refused, `count`=3.
- **Wrap:** 10 push/resolve pairs with alternating predictions and matching outcomes, one in flight at a time → all hits, `count` never exceeds 1, `branch_cnt`=10.
- **Simultaneous push and miss:** `count`=2, then a push and a mispredicting resolve in one cycle → `count`=0 and the pushed entry is gone.
- **Reset mid-operation and saturation:**
  - Reset with `count`=3 and `res_valid` high → all outputs at reset values next cycle.
  - With CNT_W=2, 5 misses → `miss_cnt` holds at 3.
  - Build without the macro → both counters read 0.
